axi_cfg_regs: RTL and testbench

//  AXI-style single-clock responder: register bank behind the *_slave0 aw/w/b and ar/r channels.

---
 rtl/axi_cfg_pkg.sv | 49 ++++
 rtl/axi_cfg_decode.sv | 23 ++
 rtl/axi_cfg_regs.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_cfg_regs.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cfg_pkg.sv
// Shared types and constants for the AXI-style configuration register bank.
package axi_cfg_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [IDX_W-1:0] REG_SRC  = 2'd0;
  localparam logic [IDX_W-1:0] REG_DST  = 2'd1;
  localparam logic [IDX_W-1:0] REG_LEN  = 2'd2;
  localparam logic [IDX_W-1:0] REG_CTRL = 2'd3;

  // Address channel payload, shared by aw and ar (44 bits).
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } aw_t;

  typedef aw_t ar_t;

  // Write data beat (73 bits).
  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [DATA_W-1:0] data;
  } w_t;

  // Write response (6 bits).
  typedef struct packed {
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } b_t;

  // Read data beat (71 bits).
  typedef struct packed {
    logic              last;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } r_t;

endpackage

// File: rtl/axi_cfg_decode.sv
// Address/length decode shared by the read and write state machines.
module axi_cfg_decode
  import axi_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned STRIDE_LOG2 = 7
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_err
);

  logic w_hit;

  // Aligned to the register stride and inside the bank.
  assign w_hit = (i_addr[STRIDE_LOG2-1:0] == '0) &&
                 ((i_addr >> STRIDE_LOG2) < ADDR_W'(NUM_REGS));
  assign o_idx = i_addr[STRIDE_LOG2 +: IDX_W];
  // Only single-beat accesses to a valid register are legal.
  assign o_err = !w_hit || (i_len != '0);

endmodule

// File: rtl/axi_cfg_regs.sv
// Configuration register bank for the DMA datapath behind AXI-style aw/w/b and ar/r channels.
// Registers src/dst/len drive cfg_* directly; a write of bit0 to ctrl pulses cfg_start and
// raises busy until done_in.
module axi_cfg_regs
  import axi_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned STRIDE_LOG2 = 7
) (
  input  logic          clk,
  input  logic          rst_bar,
  input  logic [43:0]   w_slave0_aw_dat,
  input  logic          w_slave0_aw_vld,
  output logic          w_slave0_aw_rdy,
  input  logic [72:0]   w_slave0_w_dat,
  input  logic          w_slave0_w_vld,
  output logic          w_slave0_w_rdy,
  output logic [5:0]    w_slave0_b_dat,
  output logic          w_slave0_b_vld,
  input  logic          w_slave0_b_rdy,
  input  logic [43:0]   r_slave0_ar_dat,
  input  logic          r_slave0_ar_vld,
  output logic          r_slave0_ar_rdy,
  output logic [70:0]   r_slave0_r_dat,
  output logic          r_slave0_r_vld,
  input  logic          r_slave0_r_rdy,
  output logic [63:0]   cfg_src_addr,
  output logic [63:0]   cfg_dst_addr,
  output logic [63:0]   cfg_len,
  output logic          cfg_start,
  input  logic          done_in
);

  localparam int unsigned DATA_REGS = 3;

  localparam logic [1:0] ST_WI = 2'd0;
  localparam logic [1:0] ST_WD = 2'd1;
  localparam logic [1:0] ST_WB = 2'd2;
  localparam logic       ST_RI = 1'b0;
  localparam logic       ST_RD = 1'b1;

  aw_t w_aw;
  ar_t w_ar;
  w_t  w_w;
  b_t  w_b;
  r_t  w_r;

  assign w_aw = w_slave0_aw_dat;
  assign w_ar = r_slave0_ar_dat;
  assign w_w  = w_slave0_w_dat;

  // Write side state
  logic [1:0]        r_wstate;
  logic [ID_W-1:0]   r_wid;
  logic [IDX_W-1:0]  r_widx;
  logic [LEN_W-1:0]  r_wlen;
  logic [LEN_W-1:0]  r_wcnt;
  logic              r_werr;

  // Read side state
  logic              r_rstate;
  logic [ID_W-1:0]   r_rid;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcnt;
  logic              r_rerr;
  logic [DATA_W-1:0] r_rdata;

  // Register bank and control
  logic [DATA_W-1:0] r_regs [DATA_REGS];
  logic              r_start;
  logic              r_busy;

  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_err;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_rd_err;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_beat;
  logic              w_final;
  logic              w_err_nxt;
  logic              w_commit;
  logic              w_start_set;
  logic              w_rlast;

  axi_cfg_decode #(
    .NUM_REGS    (NUM_REGS),
    .STRIDE_LOG2 (STRIDE_LOG2)
  ) u_wr_dec (
    .i_addr (w_aw.addr),
    .i_len  (w_aw.len),
    .o_idx  (w_wr_idx),
    .o_err  (w_wr_err)
  );

  axi_cfg_decode #(
    .NUM_REGS    (NUM_REGS),
    .STRIDE_LOG2 (STRIDE_LOG2)
  ) u_rd_dec (
    .i_addr (w_ar.addr),
    .i_len  (w_ar.len),
    .o_idx  (w_rd_idx),
    .o_err  (w_rd_err)
  );

  // Ready is held low while reset is asserted even though the FSM sits in idle.
  assign w_slave0_aw_rdy = (r_wstate == ST_WI) && rst_bar;
  assign w_slave0_w_rdy  = (r_wstate == ST_WD);
  assign w_slave0_b_vld  = (r_wstate == ST_WB);
  assign r_slave0_ar_rdy = (r_rstate == ST_RI) && rst_bar;
  assign r_slave0_r_vld  = (r_rstate == ST_RD);

  assign w_beat  = w_slave0_w_vld && w_slave0_w_rdy;
  assign w_final = (r_wcnt == r_wlen);
  // last must coincide with the final beat; a mismatch either way is an error.
  assign w_err_nxt   = r_werr || (w_w.last != w_final);
  assign w_commit    = w_beat && !w_err_nxt;
  assign w_start_set = w_commit && (r_widx == REG_CTRL) && w_w.strb[0] && w_w.data[0];

  assign w_b.resp       = r_werr ? RESP_SLVERR : RESP_OKAY;
  assign w_b.id         = r_wid;
  assign w_slave0_b_dat = w_b;

  assign w_rlast        = (r_rcnt == r_rlen);
  assign w_r.last       = w_rlast;
  assign w_r.resp       = r_rerr ? RESP_SLVERR : RESP_OKAY;
  assign w_r.data       = r_rdata;
  assign w_r.id         = r_rid;
  assign r_slave0_r_dat = w_r;

  assign cfg_src_addr = r_regs[REG_SRC];
  assign cfg_dst_addr = r_regs[REG_DST];
  assign cfg_len      = r_regs[REG_LEN];
  assign cfg_start    = r_start;

  // Read mux; ctrl reads back only the busy flag.
  always_comb begin
    w_rd_val = '0;
    case (w_rd_idx)
      REG_SRC:  w_rd_val = r_regs[REG_SRC];
      REG_DST:  w_rd_val = r_regs[REG_DST];
      REG_LEN:  w_rd_val = r_regs[REG_LEN];
      REG_CTRL: w_rd_val = {{(DATA_W-1){1'b0}}, r_busy};
      default:  w_rd_val = '0;
    endcase
  end

  // Write FSM: address, data beats, response.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_wstate <= ST_WI;
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else begin
      case (r_wstate)
        ST_WI: begin
          if (w_slave0_aw_vld) begin
            r_wstate <= ST_WD;
            r_wid    <= w_aw.id;
            r_widx   <= w_wr_idx;
            r_wlen   <= w_aw.len;
            r_wcnt   <= '0;
            r_werr   <= w_wr_err;
          end
        end
        ST_WD: begin
          if (w_beat) begin
            r_werr <= w_err_nxt;
            // Stop on count==len so len=255 never wraps the counter.
            if (w_final) r_wstate <= ST_WB;
            else         r_wcnt   <= r_wcnt + 8'd1;
          end
        end
        ST_WB: begin
          if (w_slave0_b_rdy) r_wstate <= ST_WI;
        end
        default: r_wstate <= ST_WI;
      endcase
    end
  end

  // Byte-lane update of src/dst/len on a clean write beat.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      for (int j = 0; j < DATA_REGS; j++) r_regs[j] <= '0;
    end else if (w_commit) begin
      for (int j = 0; j < DATA_REGS; j++) begin
        if (r_widx == IDX_W'(j)) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (w_w.strb[k]) r_regs[j][8*k +: 8] <= w_w.data[8*k +: 8];
          end
        end
      end
    end
  end

  // Start pulse and busy flag; a start in the same cycle as done_in keeps busy set.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= w_start_set;
      if (w_start_set)  r_busy <= 1'b1;
      else if (done_in) r_busy <= 1'b0;
    end
  end

  // Read FSM: capture on ar, then replay the captured value for len+1 beats.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_rstate <= ST_RI;
      r_rid    <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        ST_RI: begin
          if (r_slave0_ar_vld) begin
            r_rstate <= ST_RD;
            r_rid    <= w_ar.id;
            r_rlen   <= w_ar.len;
            r_rcnt   <= '0;
            r_rerr   <= w_rd_err;
            r_rdata  <= w_rd_err ? '0 : w_rd_val;
          end
        end
        ST_RD: begin
          if (r_slave0_r_rdy) begin
            if (w_rlast) r_rstate <= ST_RI;
            else         r_rcnt   <= r_rcnt + 8'd1;
          end
        end
        default: r_rstate <= ST_RI;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cfg_regs.sv
// Self-checking bench for axi_cfg_regs: directed cases then randomized traffic against a
// behavioural register model.
module tb_axi_cfg_regs;
  import axi_cfg_pkg::*;

  localparam int BUDGET = 64;

  logic        clk = 1'b0;
  logic        rst_bar = 1'b0;
  logic [43:0] aw_dat = '0;
  logic        aw_vld = 1'b0;
  logic        aw_rdy;
  logic [72:0] w_dat = '0;
  logic        w_vld = 1'b0;
  logic        w_rdy;
  logic [5:0]  b_dat;
  logic        b_vld;
  logic        b_rdy = 1'b0;
  logic [43:0] ar_dat = '0;
  logic        ar_vld = 1'b0;
  logic        ar_rdy;
  logic [70:0] r_dat;
  logic        r_vld;
  logic        r_rdy = 1'b0;
  logic [63:0] cfg_src;
  logic [63:0] cfg_dst;
  logic [63:0] cfg_len;
  logic        cfg_start;
  logic        done_in = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: three data registers and the busy flag.
  logic [63:0] m_regs [3];
  logic        m_busy;

  always #5 clk = ~clk;

  axi_cfg_regs u_dut (
    .clk             (clk),
    .rst_bar         (rst_bar),
    .w_slave0_aw_dat (aw_dat),
    .w_slave0_aw_vld (aw_vld),
    .w_slave0_aw_rdy (aw_rdy),
    .w_slave0_w_dat  (w_dat),
    .w_slave0_w_vld  (w_vld),
    .w_slave0_w_rdy  (w_rdy),
    .w_slave0_b_dat  (b_dat),
    .w_slave0_b_vld  (b_vld),
    .w_slave0_b_rdy  (b_rdy),
    .r_slave0_ar_dat (ar_dat),
    .r_slave0_ar_vld (ar_vld),
    .r_slave0_ar_rdy (ar_rdy),
    .r_slave0_r_dat  (r_dat),
    .r_slave0_r_vld  (r_vld),
    .r_slave0_r_rdy  (r_rdy),
    .cfg_src_addr    (cfg_src),
    .cfg_dst_addr    (cfg_dst),
    .cfg_len         (cfg_len),
    .cfg_start       (cfg_start),
    .done_in         (done_in)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a % 128 == 0) && (a / 128 < 4);
  endfunction

  function automatic logic [63:0] m_read(input logic [31:0] a);
    int idx;
    idx = int'(a / 128);
    if (idx == 3) return {63'b0, m_busy};
    return m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int j = 0; j < 3; j++) m_regs[j] = '0;
    m_busy = 1'b0;
  endtask

  task automatic check_cfg();
    check_eq("cfg_src_addr", cfg_src, m_regs[0]);
    check_eq("cfg_dst_addr", cfg_dst, m_regs[1]);
    check_eq("cfg_len", cfg_len, m_regs[2]);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    m_busy = 1'b0;
  endtask

  // Full write transaction; last_at is the beat index carrying last.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [63:0] data, input logic [7:0] strb, input int last_at,
                           input bit done_same, input int hold);
    bit          err;
    bit          start;
    int          idx;
    int          t;
    logic [5:0]  exp_b;
    w_t          w;
    err   = !m_hit(addr) || (len != 8'd0) || (last_at != int'(len));
    start = 1'b0;
    exp_b = {err ? 2'b10 : 2'b00, id};
    @(negedge clk);
    aw_vld = 1'b1;
    aw_dat = {len, addr, id};
    t = 0;
    while (!aw_rdy && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check_eq("aw_rdy", 64'(aw_rdy), 64'd1);
    @(negedge clk);
    aw_vld = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      w.strb  = strb;
      w.last  = (beat == last_at);
      w.data  = data;
      w_dat   = w;
      w_vld   = 1'b1;
      done_in = done_same && (beat == int'(len));
      t = 0;
      while (!w_rdy && t < BUDGET) begin
        @(negedge clk);
        t++;
      end
      check_eq("w_rdy", 64'(w_rdy), 64'd1);
      @(negedge clk);
      w_vld   = 1'b0;
      done_in = 1'b0;
      if (beat < int'(len)) check_eq("b_vld_early", 64'(b_vld), 64'd0);
    end
    if (!err) begin
      idx = int'(addr / 128);
      if (idx == 3) begin
        start = strb[0] && data[0];
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (strb[k]) m_regs[idx][8*k +: 8] = data[8*k +: 8];
        end
      end
    end
    if (start)          m_busy = 1'b1;
    else if (done_same) m_busy = 1'b0;
    check_eq("cfg_start", 64'(cfg_start), 64'(start));
    check_cfg();
    check_eq("b_vld", 64'(b_vld), 64'd1);
    for (int h = 0; h < hold; h++) begin
      check_eq("b_dat_hold", 64'(b_dat), 64'(exp_b));
      check_eq("b_vld_hold", 64'(b_vld), 64'd1);
      @(negedge clk);
    end
    check_eq("b_dat", 64'(b_dat), 64'(exp_b));
    b_rdy = 1'b1;
    @(negedge clk);
    b_rdy = 1'b0;
    check_eq("b_vld_drop", 64'(b_vld), 64'd0);
    check_eq("cfg_start_off", 64'(cfg_start), 64'd0);
  endtask

  // Full read transaction with an optional stall on the first beat.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int hold);
    bit          err;
    logic [63:0] exp;
    int          t;
    int          hh;
    r_t          r;
    err = !m_hit(addr) || (len != 8'd0);
    exp = err ? 64'd0 : m_read(addr);
    @(negedge clk);
    ar_vld = 1'b1;
    ar_dat = {len, addr, id};
    t = 0;
    while (!ar_rdy && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check_eq("ar_rdy", 64'(ar_rdy), 64'd1);
    @(negedge clk);
    ar_vld = 1'b0;
    check_eq("r_vld_latency", 64'(r_vld), 64'd1);
    for (int beat = 0; beat <= int'(len); beat++) begin
      hh = (beat == 0) ? hold : int'($urandom_range(0, 1));
      for (int h = 0; h <= hh; h++) begin
        if (h > 0) @(negedge clk);
        r = r_dat;
        check_eq("r_vld", 64'(r_vld), 64'd1);
        check_eq("r_data", r.data, exp);
        check_eq("r_ctl", 64'({r.last, r.resp, r.id}),
                 64'({beat == int'(len), err ? 2'b10 : 2'b00, id}));
      end
      r_rdy = 1'b1;
      @(negedge clk);
      r_rdy = 1'b0;
    end
    check_eq("r_vld_drop", 64'(r_vld), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] old_v;
    logic [63:0] new_v;
    int          sel;
    r_t          r;

    m_reset();
    repeat (3) @(negedge clk);
    // Reset state
    check_eq("rst_aw_rdy", 64'(aw_rdy), 64'd0);
    check_eq("rst_ar_rdy", 64'(ar_rdy), 64'd0);
    check_eq("rst_w_rdy", 64'(w_rdy), 64'd0);
    check_eq("rst_b_vld", 64'(b_vld), 64'd0);
    check_eq("rst_r_vld", 64'(r_vld), 64'd0);
    check_eq("rst_cfg_start", 64'(cfg_start), 64'd0);
    check_cfg();
    rst_bar = 1'b1;
    @(negedge clk);
    check_eq("post_rst_aw_rdy", 64'(aw_rdy), 64'd1);
    check_eq("post_rst_ar_rdy", 64'(ar_rdy), 64'd1);

    // Basic write to src, write/read dst.
    axi_write(32'h0, 4'd3, 8'd0, 64'h1000, 8'hFF, 0, 1'b0, 0);
    check_eq("src_1000", cfg_src, 64'h1000);
    axi_write(32'h80, 4'd1, 8'd0, 64'h4000, 8'hFF, 0, 1'b0, 1);
    axi_read(32'h80, 4'd5, 8'd0, 0);
    check_eq("dst_4000", cfg_dst, 64'h4000);

    // Start pulse, busy readback, done clears busy.
    axi_write(32'h180, 4'd2, 8'd0, 64'h1, 8'hFF, 0, 1'b0, 0);
    axi_read(32'h180, 4'd6, 8'd0, 0);
    pulse_done();
    axi_read(32'h180, 4'd7, 8'd0, 0);

    // Byte-strobe merge.
    axi_write(32'h100, 4'd4, 8'd0, 64'h3F00, 8'hFF, 0, 1'b0, 0);
    axi_write(32'h100, 4'd4, 8'd0, 64'hFF, 8'h01, 0, 1'b0, 0);
    check_eq("len_merge", cfg_len, 64'h3FFF);

    // Error cases: out of range, misaligned, multi-beat, early last.
    axi_write(32'h200, 4'd8, 8'd0, 64'hDEAD, 8'hFF, 0, 1'b0, 0);
    axi_write(32'h40, 4'd9, 8'd0, 64'hBEEF, 8'hFF, 0, 1'b0, 0);
    axi_write(32'h0, 4'd10, 8'd1, 64'hCAFE, 8'hFF, 1, 1'b0, 0);
    axi_write(32'h80, 4'd11, 8'd2, 64'hF00D, 8'hFF, 0, 1'b0, 0);
    axi_read(32'h200, 4'd12, 8'd0, 0);
    axi_read(32'h80, 4'd13, 8'd2, 1);

    // Backpressure on b and r.
    axi_write(32'h80, 4'd14, 8'd0, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 1'b0, 5);
    axi_read(32'h80, 4'd15, 8'd0, 5);

    // Start and done in the same cycle leaves busy set.
    axi_write(32'h180, 4'd1, 8'd0, 64'h1, 8'hFF, 0, 1'b1, 0);
    axi_read(32'h180, 4'd2, 8'd0, 0);
    pulse_done();

    // Longest burst: counter must reach 255 without wrapping.
    axi_write(32'h0, 4'd3, 8'd255, 64'h5555, 8'hFF, 255, 1'b0, 0);
    axi_read(32'h100, 4'd4, 8'd255, 0);

    // Read capture and write commit on the same edge: read returns the old value.
    old_v = m_regs[0];
    new_v = 64'hA5A5_0000_1111_2222;
    @(negedge clk);
    aw_vld = 1'b1;
    aw_dat = {8'd0, 32'h0, 4'd9};
    check_eq("same_aw_rdy", 64'(aw_rdy), 64'd1);
    @(negedge clk);
    aw_vld = 1'b0;
    w_dat  = {8'hFF, 1'b1, new_v};
    w_vld  = 1'b1;
    ar_dat = {8'd0, 32'h0, 4'd10};
    ar_vld = 1'b1;
    check_eq("same_w_rdy", 64'(w_rdy), 64'd1);
    check_eq("same_ar_rdy", 64'(ar_rdy), 64'd1);
    @(negedge clk);
    w_vld  = 1'b0;
    ar_vld = 1'b0;
    m_regs[0] = new_v;
    r = r_dat;
    check_eq("same_r_data", r.data, old_v);
    check_eq("same_b_vld", 64'(b_vld), 64'd1);
    check_cfg();
    r_rdy = 1'b1;
    b_rdy = 1'b1;
    @(negedge clk);
    r_rdy = 1'b0;
    b_rdy = 1'b0;
    check_eq("same_r_drop", 64'(r_vld), 64'd0);
    check_eq("same_b_drop", 64'(b_vld), 64'd0);

    // Reset while in the data phase.
    @(negedge clk);
    aw_vld = 1'b1;
    aw_dat = {8'd0, 32'h80, 4'd7};
    @(negedge clk);
    aw_vld = 1'b0;
    check_eq("mid_w_rdy", 64'(w_rdy), 64'd1);
    rst_bar = 1'b0;
    #1;
    m_reset();
    check_eq("mid_rst_w_rdy", 64'(w_rdy), 64'd0);
    check_eq("mid_rst_aw_rdy", 64'(aw_rdy), 64'd0);
    check_eq("mid_rst_ar_rdy", 64'(ar_rdy), 64'd0);
    check_eq("mid_rst_b_vld", 64'(b_vld), 64'd0);
    check_cfg();
    @(negedge clk);
    rst_bar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_b", 64'(b_vld), 64'd0);
    end
    check_eq("mid_rst_aw_rdy_back", 64'(aw_rdy), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       addr = 32'((sel % 4) * 128);
      else if (sel == 8) addr = 32'h200 + 32'($urandom_range(0, 4) * 128);
      else               addr = 32'($urandom_range(0, 3) * 128 + $urandom_range(1, 127));
      len  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
      data = {$urandom, $urandom};
      strb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if (addr == 32'h180) strb = 8'hFF;
      case ($urandom_range(0, 3))
        0, 1: axi_write(addr, 4'($urandom_range(0, 15)), len, data, strb,
                        (len == 8'd0) ? 0 : int'($urandom_range(0, int'(len))),
                        ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        2:    axi_read(addr, 4'($urandom_range(0, 15)), len, int'($urandom_range(0, 3)));
        default: pulse_done();
      endcase
    end
    check_cfg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
